// File: rtl/screen_select_judge.sv
// screen_select_judge: consumer side of the four-screen generator handshake.
// Requests screens, snapshots them on Screen_Done, judges the player's one-hot
// selection against the main screen, and tracks rounds, strikes and a timeout.
module screen_select_judge #(
  parameter int ROUNDS       = 4,
  parameter int MAX_STRIKES  = 3,
  parameter int ROUND_CYCLES = 1000,
  parameter int TMR_W        = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic [3:0] Sel_Btn,
  input  logic       Screen_Done,
  input  logic [1:0] First_Screen,
  input  logic [1:0] Second_Screen,
  input  logic [1:0] Third_Screen,
  input  logic [1:0] Fourth_Screen,
  input  logic [1:0] Main_Screen,
  output logic       New_Screens,
  output logic       Correct,
  output logic       Strike,
  output logic [3:0] Round,
  output logic [1:0] Strikes,
  output logic       Gen_Err,
  output logic       Busy,
  output logic       Win,
  output logic       Lose
);

  localparam logic [3:0]       ROUNDS_V   = 4'(ROUNDS);
  localparam logic [1:0]       STRIKES_V  = 2'(MAX_STRIKES);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(ROUND_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_GEN,
    LATCH,
    ARMED,
    WIN,
    LOSE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             done_prev;
  logic [1:0]       snap [4];
  logic [1:0]       snap_main;
  logic [TMR_W-1:0] timer;

  logic       done_rise;
  logic       valid_press;
  logic [1:0] sel_val;
  logic       match;
  logic       timeout;
  logic       dup;
  logic [3:0] round_inc;
  logic [1:0] strikes_inc;

  logic game_clear;
  logic req_pulse;
  logic latch_en;
  logic gen_err_set;
  logic timer_clr;
  logic timer_inc;
  logic correct_ev;
  logic strike_ev;
  logic win_set;
  logic lose_set;

  // Decode helpers: edge detect, press validity, selected screen and limits.
  always_comb begin
    done_rise   = Screen_Done && !done_prev;
    valid_press = (Sel_Btn != 4'b0000) && ((Sel_Btn & (Sel_Btn - 4'd1)) == 4'b0000);
    case (Sel_Btn)
      4'b0010: sel_val = snap[1];
      4'b0100: sel_val = snap[2];
      4'b1000: sel_val = snap[3];
      default: sel_val = snap[0];
    endcase
    match       = (sel_val == snap_main);
    timeout     = (timer == TIMER_LAST);
    dup         = (First_Screen  == Second_Screen) || (First_Screen  == Third_Screen) ||
                  (First_Screen  == Fourth_Screen) || (Second_Screen == Third_Screen) ||
                  (Second_Screen == Fourth_Screen) || (Third_Screen  == Fourth_Screen);
    round_inc   = Round + 4'd1;
    strikes_inc = Strikes + 2'd1;
  end

  // Next-state logic and the per-cycle event strobes that drive the datapath.
  always_comb begin
    state_next  = state;
    game_clear  = 1'b0;
    req_pulse   = 1'b0;
    latch_en    = 1'b0;
    gen_err_set = 1'b0;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;
    correct_ev  = 1'b0;
    strike_ev   = 1'b0;
    win_set     = 1'b0;
    lose_set    = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (Start) begin
          state_next = REQ;
          game_clear = 1'b1;
        end
      end
      REQ: begin
        req_pulse  = 1'b1;
        state_next = WAIT_GEN;
      end
      WAIT_GEN: begin
        if (done_rise) state_next = LATCH;
      end
      LATCH: begin
        latch_en = 1'b1;
        if (dup) begin
          gen_err_set = 1'b1;
          state_next  = REQ;
        end else begin
          timer_clr  = 1'b1;
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (valid_press) begin
          if (match) begin
            correct_ev = 1'b1;
            if (round_inc == ROUNDS_V) begin
              win_set    = 1'b1;
              state_next = WIN;
            end else begin
              state_next = REQ;
            end
          end else begin
            strike_ev = 1'b1;
            if (strikes_inc == STRIKES_V) begin
              lose_set   = 1'b1;
              state_next = LOSE;
            end else begin
              timer_clr = 1'b1;
            end
          end
        end else if (timeout) begin
          strike_ev = 1'b1;
          if (strikes_inc == STRIKES_V) begin
            lose_set   = 1'b1;
            state_next = LOSE;
          end else begin
            state_next = REQ;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_next;
  end

  // Datapath: snapshot, timer, counters, sticky flags and registered pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      done_prev   <= 1'b0;
      for (int i = 0; i < 4; i++) snap[i] <= 2'd0;
      snap_main   <= 2'd0;
      timer       <= '0;
      New_Screens <= 1'b0;
      Correct     <= 1'b0;
      Strike      <= 1'b0;
      Round       <= 4'd0;
      Strikes     <= 2'd0;
      Gen_Err     <= 1'b0;
      Win         <= 1'b0;
      Lose        <= 1'b0;
    end else begin
      done_prev   <= Screen_Done;
      New_Screens <= req_pulse;
      Correct     <= correct_ev;
      Strike      <= strike_ev;
      if (latch_en) begin
        snap[0]   <= First_Screen;
        snap[1]   <= Second_Screen;
        snap[2]   <= Third_Screen;
        snap[3]   <= Fourth_Screen;
        snap_main <= Main_Screen;
      end
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + 1'b1;
      if (game_clear) begin
        Round   <= 4'd0;
        Strikes <= 2'd0;
        Gen_Err <= 1'b0;
        Win     <= 1'b0;
        Lose    <= 1'b0;
      end
      if (correct_ev && (Round < ROUNDS_V))   Round   <= round_inc;
      if (strike_ev && (Strikes < STRIKES_V)) Strikes <= strikes_inc;
      if (gen_err_set) Gen_Err <= 1'b1;
      if (win_set)     Win     <= 1'b1;
      if (lose_set)    Lose    <= 1'b1;
    end
  end

  // Busy covers every in-game state.
  always_comb begin
    Busy = !((state == IDLE) || (state == WIN) || (state == LOSE));
  end

endmodule

// File: tb/tb_screen_select_judge.sv
// Testbench for screen_select_judge: table vectors, directed corner sequences
// and randomized games checked against a round/strike level game model.
module tb_screen_select_judge;

  localparam int ROUNDS       = 4;
  localparam int MAX_STRIKES  = 3;
  localparam int ROUND_CYCLES = 20;
  localparam int TMR_W        = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Start = 1'b0;
  logic [3:0] Sel_Btn = 4'b0000;
  logic       Screen_Done = 1'b0;
  logic [1:0] First_Screen = 2'd0, Second_Screen = 2'd0, Third_Screen = 2'd0;
  logic [1:0] Fourth_Screen = 2'd0, Main_Screen = 2'd0;
  logic       New_Screens, Correct, Strike, Gen_Err, Busy, Win, Lose;
  logic [3:0] Round;
  logic [1:0] Strikes;

  screen_select_judge #(
    .ROUNDS(ROUNDS), .MAX_STRIKES(MAX_STRIKES),
    .ROUND_CYCLES(ROUND_CYCLES), .TMR_W(TMR_W)
  ) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Sel_Btn(Sel_Btn),
    .Screen_Done(Screen_Done),
    .First_Screen(First_Screen), .Second_Screen(Second_Screen),
    .Third_Screen(Third_Screen), .Fourth_Screen(Fourth_Screen),
    .Main_Screen(Main_Screen),
    .New_Screens(New_Screens), .Correct(Correct), .Strike(Strike),
    .Round(Round), .Strikes(Strikes), .Gen_Err(Gen_Err), .Busy(Busy),
    .Win(Win), .Lose(Lose)
  );

  // Free-running clock.
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int ns_cnt = 0, cor_cnt = 0, str_cnt = 0;

  // Count pulses on the inactive edge so each one-cycle pulse is seen once.
  always @(negedge CLK) begin
    if (New_Screens) ns_cnt++;
    if (Correct)     cor_cnt++;
    if (Strike)      str_cnt++;
  end

  // Game-level reference state.
  int         m_round, m_strikes, m_gen_err, m_win, m_lose, m_elapsed;
  bit         m_need;
  logic [1:0] m_scr [4];
  logic [1:0] m_main;

  typedef struct {
    logic [1:0] s0, s1, s2, s3, m;
    logic [3:0] btn;
    int         exp_c, exp_s;
  } vec_t;
  vec_t vecs [8];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic resetDut();
    RST = 1'b0; Start = 1'b0; Sel_Btn = 4'b0000; Screen_Done = 1'b0;
    repeat (2) tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic startGame();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    m_round = 0; m_strikes = 0; m_gen_err = 0; m_win = 0; m_lose = 0;
    m_elapsed = 0; m_need = 1'b1;
  endtask

  task automatic waitNewScreens();
    int n;
    n = 0;
    while (!New_Screens && n < 30) begin
      tick();
      n++;
    end
    checkOutput("new_screens_wait", int'(New_Screens), 1);
  endtask

  // Behaves as the generator: answers a Button pulse with a fresh screen set.
  task automatic deliver(input logic [1:0] s0, s1, s2, s3, m);
    waitNewScreens();
    Screen_Done = 1'b0;
    tick();
    tick();
    First_Screen = s0; Second_Screen = s1; Third_Screen = s2; Fourth_Screen = s3;
    Main_Screen = m;
    Screen_Done = 1'b1;
    tick();
    tick();
    First_Screen = 2'($urandom); Second_Screen = 2'($urandom);
    Third_Screen = 2'($urandom); Fourth_Screen = 2'($urandom);
    Main_Screen = 2'($urandom);
    m_scr[0] = s0; m_scr[1] = s1; m_scr[2] = s2; m_scr[3] = s3;
    m_main = m;
    m_elapsed = 0;
  endtask

  task automatic press(input logic [3:0] btn);
    Sel_Btn = btn;
    tick();
    Sel_Btn = 4'b0000;
  endtask

  // One armed cycle: predict from game rules, apply, compare.
  task automatic modelStep(input logic [3:0] btn);
    int exp_c, exp_s, idx;
    exp_c = 0; exp_s = 0; idx = 0;
    if ($countones(btn) == 1) begin
      for (int i = 0; i < 4; i++) if (btn[i]) idx = i;
      if (m_scr[idx] == m_main) begin
        exp_c = 1;
        m_round++;
        if (m_round == ROUNDS) m_win = 1;
        else m_need = 1'b1;
      end else begin
        exp_s = 1;
        m_strikes++;
        if (m_strikes == MAX_STRIKES) m_lose = 1;
        else m_elapsed = 0;
      end
    end else if (m_elapsed == ROUND_CYCLES - 1) begin
      exp_s = 1;
      m_strikes++;
      if (m_strikes == MAX_STRIKES) m_lose = 1;
      else m_need = 1'b1;
    end else begin
      m_elapsed++;
    end
    press(btn);
    checkOutput("rnd_correct", int'(Correct), exp_c);
    checkOutput("rnd_strike", int'(Strike), exp_s);
    checkOutput("rnd_round", int'(Round), m_round);
    checkOutput("rnd_strikes", int'(Strikes), m_strikes);
    checkOutput("rnd_win", int'(Win), m_win);
    checkOutput("rnd_lose", int'(Lose), m_lose);
    checkOutput("rnd_busy", int'(Busy), (m_win != 0 || m_lose != 0) ? 0 : 1);
  endtask

  task automatic randomDelivery();
    logic [1:0] p [4];
    logic [1:0] t;
    int j;
    bit bad;
    for (int i = 0; i < 4; i++) p[i] = 2'(i);
    for (int i = 3; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    bad = ($urandom_range(0, 4) == 0);
    if (bad) p[$urandom_range(1, 3)] = p[0];
    deliver(p[0], p[1], p[2], p[3], 2'($urandom));
    if (bad) m_gen_err = 1;
    else m_need = 1'b0;
    checkOutput("rnd_gen_err", int'(Gen_Err), m_gen_err);
    checkOutput("rnd_no_strike_latch", int'(Strike), 0);
  endtask

  task automatic applyStimulus(input int k);
    resetDut();
    startGame();
    deliver(vecs[k].s0, vecs[k].s1, vecs[k].s2, vecs[k].s3, vecs[k].m);
    press(vecs[k].btn);
    checkOutput($sformatf("vec%0d_correct", k), int'(Correct), vecs[k].exp_c);
    checkOutput($sformatf("vec%0d_strike", k), int'(Strike), vecs[k].exp_s);
    checkOutput($sformatf("vec%0d_round", k), int'(Round), vecs[k].exp_c);
    checkOutput($sformatf("vec%0d_strikes", k), int'(Strikes), vecs[k].exp_s);
  endtask

  initial begin
    int c0, ns0, r, ci;
    logic [3:0] inval [5];
    inval[0] = 4'b0000; inval[1] = 4'b0011; inval[2] = 4'b0110;
    inval[3] = 4'b1111; inval[4] = 4'b1010;

    vecs[0] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 4'b0100, 1, 0};
    vecs[1] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd3, 4'b0001, 0, 1};
    vecs[2] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 4'b0001, 1, 0};
    vecs[3] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 4'b1000, 1, 0};
    vecs[4] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 4'b0010, 0, 1};
    vecs[5] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 4'b1000, 1, 0};
    vecs[6] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 4'b0011, 0, 0};
    vecs[7] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 4'b0000, 0, 0};

    // Reset state.
    tick();
    checkOutput("rst_new_screens", int'(New_Screens), 0);
    checkOutput("rst_correct", int'(Correct), 0);
    checkOutput("rst_strike", int'(Strike), 0);
    checkOutput("rst_round", int'(Round), 0);
    checkOutput("rst_busy", int'(Busy), 0);
    checkOutput("rst_flags", int'({Gen_Err, Win, Lose, Strikes}), 0);
    RST = 1'b1;
    tick();

    // First correct press and New_Screens latency, then play to a win.
    startGame();
    checkOutput("start_busy", int'(Busy), 1);
    deliver(2'd2, 2'd0, 2'd3, 2'd1, 2'd3);
    press(4'b0100);
    checkOutput("p1_correct", int'(Correct), 1);
    checkOutput("p1_round", int'(Round), 1);
    checkOutput("p1_ns_early", int'(New_Screens), 0);
    tick();
    checkOutput("p1_ns_2cyc", int'(New_Screens), 1);
    checkOutput("p1_correct_done", int'(Correct), 0);
    for (int k = 2; k <= ROUNDS; k++) begin
      deliver(2'd2, 2'd0, 2'd3, 2'd1, 2'd3);
      press(4'b0100);
      checkOutput("win_path_correct", int'(Correct), 1);
    end
    checkOutput("win_flag", int'(Win), 1);
    checkOutput("win_busy", int'(Busy), 0);
    checkOutput("win_round", int'(Round), ROUNDS);
    tick();
    c0 = ns_cnt + cor_cnt + str_cnt;
    press(4'b0100); press(4'b0001); press(4'b1000); tick(); tick();
    checkOutput("win_no_pulses", ns_cnt + cor_cnt + str_cnt, c0);
    checkOutput("win_hold", int'(Win), 1);

    // Three wrong presses lead to a loss without new screens.
    startGame();
    checkOutput("restart_win_clear", int'(Win), 0);
    checkOutput("restart_round_clear", int'(Round), 0);
    deliver(2'd0, 2'd1, 2'd2, 2'd3, 2'd1);
    ns0 = ns_cnt;
    for (int k = 1; k <= MAX_STRIKES; k++) begin
      press(4'b0001);
      checkOutput("lose_strike", int'(Strike), 1);
      checkOutput("lose_strikes", int'(Strikes), k);
      tick();
    end
    checkOutput("lose_flag", int'(Lose), 1);
    checkOutput("lose_busy", int'(Busy), 0);
    repeat (3) tick();
    checkOutput("lose_no_ns", ns_cnt, ns0);

    // Timeout strike exactly ROUND_CYCLES cycles after arming.
    startGame();
    checkOutput("restart_lose_clear", int'(Lose), 0);
    deliver(2'd0, 2'd1, 2'd2, 2'd3, 2'd2);
    repeat (ROUND_CYCLES - 1) tick();
    checkOutput("to_not_early", int'(Strike), 0);
    tick();
    checkOutput("to_strike", int'(Strike), 1);
    checkOutput("to_strikes", int'(Strikes), 1);
    tick();
    checkOutput("to_new_screens", int'(New_Screens), 1);

    // Bad screen set: Gen_Err, re-request, no strike; multi-bit press ignored.
    c0 = str_cnt;
    deliver(2'd1, 2'd1, 2'd2, 2'd3, 2'd0);
    checkOutput("generr_set", int'(Gen_Err), 1);
    tick();
    checkOutput("generr_rerequest", int'(New_Screens), 1);
    checkOutput("generr_no_strike", str_cnt, c0);
    deliver(2'd3, 2'd1, 2'd0, 2'd2, 2'd0);
    press(4'b0011);
    checkOutput("multi_no_correct", int'(Correct), 0);
    checkOutput("multi_no_strike", int'(Strike), 0);
    press(4'b0100);
    checkOutput("after_err_correct", int'(Correct), 1);
    checkOutput("generr_sticky", int'(Gen_Err), 1);
    checkOutput("strikes_kept", int'(Strikes), 1);

    // Asynchronous reset while waiting for the generator.
    tick();
    checkOutput("pre_rst_ns", int'(New_Screens), 1);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("arst_ns", int'(New_Screens), 0);
    checkOutput("arst_round", int'(Round), 0);
    checkOutput("arst_busy", int'(Busy), 0);
    checkOutput("arst_flags", int'({Gen_Err, Win, Lose, Strikes}), 0);
    tick();
    RST = 1'b1;
    tick();
    startGame();
    checkOutput("rst_restart_round", int'(Round), 0);
    checkOutput("rst_restart_busy", int'(Busy), 1);
    deliver(2'd0, 2'd1, 2'd2, 2'd3, 2'd0);
    press(4'b0001);
    checkOutput("rst_restart_correct", int'(Round), 1);

    // Table-driven single-press vectors.
    for (int k = 0; k < 8; k++) applyStimulus(k);

    // Randomized games against the game model.
    for (int g = 0; g < 8; g++) begin
      resetDut();
      startGame();
      for (int step = 0; step < 400 && m_win == 0 && m_lose == 0; step++) begin
        if (m_need) begin
          randomDelivery();
        end else begin
          ci = 0;
          for (int i = 0; i < 4; i++) if (m_scr[i] == m_main) ci = i;
          r = $urandom_range(0, 9);
          if (r <= 3) modelStep(4'(1 << ci));
          else if (r <= 5) modelStep(4'(1 << ((ci + 1 + $urandom_range(0, 2)) % 4)));
          else if (r <= 7) modelStep(inval[$urandom_range(0, 4)]);
          else begin
            for (int k = 0; k < ROUND_CYCLES && !m_need && m_win == 0 && m_lose == 0; k++)
              modelStep(4'b0000);
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
